// File: rtl/arb_mux4to1_n_bit.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux4to1_n_bit
// Description : Four-source round-robin arbitrating mux. It has a registered
//               output stage, and each output word carries its 2-bit source tag.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux4to1_n_bit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [3:0]   v,
    output logic [3:0]   rdy,
    output logic [N-1:0] z,
    output logic [1:0]   s,
    output logic         z_valid,
    input  logic         z_ready
);

    logic [N-1:0] r_z;
    logic [1:0]   r_s;
    logic         r_z_valid;
    logic [1:0]   r_ptr;

    logic         w_load;
    logic         w_any;
    logic [1:0]   w_gnt;
    logic [N-1:0] w_gnt_data;

    assign w_load = !r_z_valid || z_ready;
    assign w_any  = |v;

    // Scan from the farthest offset back to ptr so the closest requester wins.
    always_comb begin
        w_gnt = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (v[r_ptr + 2'(k)]) begin
                w_gnt = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        case (w_gnt)
            2'd0:    w_gnt_data = a0;
            2'd1:    w_gnt_data = a1;
            2'd2:    w_gnt_data = a2;
            default: w_gnt_data = a3;
        endcase
    end

    // Gated by rst so no source believes its word was taken while in reset.
    always_comb begin
        rdy = 4'b0000;
        if (!rst && w_load && w_any) begin
            rdy[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z       <= '0;
            r_s       <= 2'd0;
            r_z_valid <= 1'b0;
            r_ptr     <= 2'd0;
        end else if (w_load) begin
            if (w_any) begin
                r_z       <= w_gnt_data;
                r_s       <= w_gnt;
                r_z_valid <= 1'b1;
                r_ptr     <= w_gnt + 2'd1;
            end else begin
                r_z_valid <= 1'b0;
            end
        end
    end

    assign z       = r_z;
    assign s       = r_s;
    assign z_valid = r_z_valid;

endmodule
`default_nettype wire

// File: doc/arb_mux4to1_n_bit.md
# arb_mux4to1_n_bit

Four-source, N-bit round-robin arbitrating multiplexer with valid/ready handshakes on every port. It gathers words from four producers onto one output channel and tags each word with a 2-bit source index. The tag is encoded exactly as the select input of the 1-to-4 N-bit demux, so a demux downstream can route replies back to the originating source. It sits at the merge point in front of a shared consumer and holds one word in a registered output stage.

## Interface
- N, 8, data width in bits of every input and of the output

- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- a0, a1, a2, a3  input  N each  source data words
- v  input  4  v[i] = source i presents a valid word on a<i>
- rdy  output  4  rdy[i] = source i's word is taken this cycle (transfer when v[i] && rdy[i])
- z  output  N  registered output word
- s  output  2  registered source index of z (0..3, same encoding as the demux select)
- z_valid  output  1  z/s hold a valid word
- z_ready  input  1  consumer accepts z this cycle (transfer when z_valid && z_ready)

## Operation
- State: output register {z, s, z_valid}; 2-bit priority pointer ptr.
- load = !z_valid || z_ready. The output stage can accept a new word this cycle.
- Grant g: the first index with v[g]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). It is defined only when |v.
- rdy[i] = load && |v && (g == i). rdy is combinational from v, z_valid and z_ready. At most one rdy bit is high.
- On a clock edge with load && |v:
  - z <= a<g>
  - s <= g
  - z_valid <= 1
  - ptr <= g+1 mod 4 (3 wraps to 0)
- On a clock edge with load && !|v: z_valid <= 0, z, s and ptr hold.
- On a clock edge with !load: everything holds. z and s stay stable while z_valid && !z_ready.
- Sources keep v[i] and a<i> stable until the transfer. Correctness of the block does not depend on this rule; a withdrawn request is simply not granted.
- Fairness: any continuously asserted request is granted within 4 output transfers.

## Timing
- Reset (asynchronous assert, any cycle, including mid-transfer): z=0, s=0, z_valid=0, ptr=0, rdy=0. Any word held in the output stage is discarded.
- Latency: a word accepted at edge k appears on z/s with z_valid=1 immediately after edge k (1 cycle).
- Throughput: 1 word/cycle when z_ready is held high.
- Simultaneous events: a consumer pop and a new accept in the same cycle are legal and produce a back-to-back output with no bubble.
- Output stall: z_ready low with z_valid high forces rdy=4'b0000. ptr is frozen.
- Empty: with v=0, z_valid falls to 0 on the first edge where load=1.

## Test plan
- Reset, then v=0 and z_ready=1 for 3 cycles -> z=0, s=0, z_valid=0, rdy=0000 throughout.
- N=8, a0=8'h10, a1=8'h21, a2=8'h32, a3=8'h43, v=1111 held, z_ready=1 -> consecutive outputs (z,s) = (10,0),(21,1),(32,2),(43,3),(10,0); rdy one-hot 0001,0010,0100,1000,0001.
- Only v[2]=1, a2 incrementing each transfer, z_ready=1 -> one word per cycle with s=2 every cycle. ptr cycles 3→3 (wrap irrelevant), with no bubbles.
- Output z=8'h21/s=1 valid, then z_ready=0 for 4 cycles with v=1111 -> z/s/z_valid unchanged and rdy=0000. After z_ready=1, the next output is from source 2.
- ptr=3 after the last grant, v=0101 -> grant source 0 (wrap), then source 2, then 0.
- Assert rst while z_valid=1 and v=1111 -> next sample shows z=0, s=0, z_valid=0. After release, the first grant goes to source 0.
